// File: rtl/div_issue_ctrl_pkg.sv
// Shared widths, funct3 encodings and FSM states for the divide issue controller.
// Also used by the optional DIV_FASTPATH_EN special-case path.
package div_issue_ctrl_pkg;

   localparam int unsigned REG_BUS_W      = 32;
   localparam int unsigned REG_ADDR_BUS_W = 5;

   localparam logic [2:0] DIV_OP_DIV  = 3'b100;
   localparam logic [2:0] DIV_OP_DIVU = 3'b101;
   localparam logic [2:0] DIV_OP_REM  = 3'b110;
   localparam logic [2:0] DIV_OP_REMU = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

   function automatic logic op_is_rem(input logic [2:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_unsigned(input logic [2:0] op);
      return op[0];
   endfunction

endpackage

// File: rtl/div_fastpath.sv
// Combinational detector/result generator for divide-by-zero and signed overflow.
// Compiled only when DIV_FASTPATH_EN is defined.
`ifdef DIV_FASTPATH_EN
module div_fastpath
   import div_issue_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = REG_BUS_W
) (
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic            hit_o,
   output logic [XLEN-1:0] res_o
);

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic div_by_zero;
   logic ovf;

   always_comb begin
      div_by_zero = (divisor_i == '0);
      ovf         = !op_is_unsigned(op_i) && (dividend_i == MIN_NEG) && (divisor_i == '1);
      hit_o       = div_by_zero | ovf;
      res_o       = '0;
      if (div_by_zero) begin
         res_o = op_is_rem(op_i) ? dividend_i : '1;
      end else if (ovf) begin
         res_o = op_is_rem(op_i) ? '0 : MIN_NEG;
      end
   end

endmodule
`endif

// File: rtl/div_issue_ctrl.sv
// EX-stage controller launching the iterative divider and writing back its result.
// Define DIV_FASTPATH_EN to resolve divide-by-zero/overflow without the divider.
module div_issue_ctrl
   import div_issue_ctrl_pkg::*;
#(
   parameter int unsigned XLEN   = REG_BUS_W,
   parameter int unsigned REG_AW = REG_ADDR_BUS_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid_i,
   input  logic              is_div_i,
   input  logic [2:0]        op_i,
   input  logic [XLEN-1:0]   rs1_data_i,
   input  logic [XLEN-1:0]   rs2_data_i,
   input  logic [REG_AW-1:0] rd_addr_i,
   input  logic              flush_i,
   output logic              div_start_o,
   output logic [XLEN-1:0]   div_dividend_o,
   output logic [XLEN-1:0]   div_divisor_o,
   output logic [2:0]        div_op_o,
   output logic [REG_AW-1:0] div_waddr_o,
   input  logic [XLEN-1:0]   div_res_i,
   input  logic              div_ready_i,
   input  logic              div_busy_i,
   input  logic [REG_AW-1:0] div_waddr_ri,
   output logic              hold_o,
   output logic              wb_we_o,
   output logic [REG_AW-1:0] wb_waddr_o,
   output logic [XLEN-1:0]   wb_wdata_o
);

   div_state_e        state_q, state_d;
   logic              start_q, start_d;
   logic [XLEN-1:0]   dividend_q, dividend_d;
   logic [XLEN-1:0]   divisor_q, divisor_d;
   logic [2:0]        op_q, op_d;
   logic [REG_AW-1:0] waddr_q, waddr_d;
   logic              we_q, we_d;
   logic [REG_AW-1:0] wb_waddr_q, wb_waddr_d;
   logic [XLEN-1:0]   wb_wdata_q, wb_wdata_d;

   logic              issue;
   logic              fp_take;
   logic [XLEN-1:0]   fp_res;

   assign issue = ex_valid_i & is_div_i & ~flush_i;

`ifdef DIV_FASTPATH_EN
   div_fastpath #(
      .XLEN(XLEN)
   ) u_fastpath (
      .op_i       (op_i),
      .dividend_i (rs1_data_i),
      .divisor_i  (rs2_data_i),
      .hit_o      (fp_take),
      .res_o      (fp_res)
   );
`else
   assign fp_take = 1'b0;
   assign fp_res  = '0;
`endif

   always_comb begin
      state_d    = state_q;
      start_d    = start_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      op_d       = op_q;
      waddr_d    = waddr_q;
      we_d       = 1'b0;
      wb_waddr_d = wb_waddr_q;
      wb_wdata_d = wb_wdata_q;
      hold_o     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            hold_o = issue | div_busy_i;
            if (issue && !div_busy_i) begin
               if (fp_take) begin
                  wb_wdata_d = fp_res;
                  wb_waddr_d = rd_addr_i;
                  we_d       = (rd_addr_i != '0);
                  state_d    = ST_DONE;
               end else begin
                  dividend_d = rs1_data_i;
                  divisor_d  = rs2_data_i;
                  op_d       = op_i;
                  waddr_d    = rd_addr_i;
                  start_d    = 1'b1;
                  state_d    = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            hold_o = 1'b1;
            // Flush takes priority over a simultaneous ready: the result is dropped.
            if (flush_i) begin
               start_d = 1'b0;
               state_d = ST_IDLE;
            end else if (div_ready_i && (div_waddr_ri == waddr_q)) begin
               wb_wdata_d = div_res_i;
               wb_waddr_d = waddr_q;
               we_d       = (waddr_q != '0);
               start_d    = 1'b0;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            start_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         start_q    <= 1'b0;
         dividend_q <= '0;
         divisor_q  <= '0;
         op_q       <= '0;
         waddr_q    <= '0;
         we_q       <= 1'b0;
         wb_waddr_q <= '0;
         wb_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         start_q    <= start_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         op_q       <= op_d;
         waddr_q    <= waddr_d;
         we_q       <= we_d;
         wb_waddr_q <= wb_waddr_d;
         wb_wdata_q <= wb_wdata_d;
      end
   end

   assign div_start_o    = start_q;
   assign div_dividend_o = dividend_q;
   assign div_divisor_o  = divisor_q;
   assign div_op_o       = op_q;
   assign div_waddr_o    = waddr_q;
   assign wb_we_o        = we_q;
   assign wb_waddr_o     = wb_waddr_q;
   assign wb_wdata_o     = wb_wdata_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural divider and RISC-V divide reference.
// Honours DIV_FASTPATH_EN when the same define is given to the bench.
module tb_div_issue_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ex_valid = 1'b0;
   logic        is_div = 1'b0;
   logic [2:0]  op = 3'b000;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic [4:0]  rd = '0;
   logic        flush = 1'b0;

   logic        div_start_o;
   logic [31:0] div_dividend_o;
   logic [31:0] div_divisor_o;
   logic [2:0]  div_op_o;
   logic [4:0]  div_waddr_o;
   logic        hold_o;
   logic        wb_we_o;
   logic [4:0]  wb_waddr_o;
   logic [31:0] wb_wdata_o;

   logic [31:0] div_res;
   logic        div_ready;
   logic        div_busy;
   logic [4:0]  div_waddr_r;

   int          compared = 0;
   int          mismatched = 0;

   int          lat_cfg = 2;
   int          cnt = 0;
   logic        rdy_q = 1'b0;
   logic [31:0] res_q = '0;
   logic [4:0]  wa_q = '0;
   logic        spur = 1'b0;
   logic        busy_force = 1'b0;

   always #5 clk = ~clk;

   div_issue_ctrl #(
      .XLEN   (32),
      .REG_AW (5)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ex_valid_i     (ex_valid),
      .is_div_i       (is_div),
      .op_i           (op),
      .rs1_data_i     (rs1),
      .rs2_data_i     (rs2),
      .rd_addr_i      (rd),
      .flush_i        (flush),
      .div_start_o    (div_start_o),
      .div_dividend_o (div_dividend_o),
      .div_divisor_o  (div_divisor_o),
      .div_op_o       (div_op_o),
      .div_waddr_o    (div_waddr_o),
      .div_res_i      (div_res),
      .div_ready_i    (div_ready),
      .div_busy_i     (div_busy),
      .div_waddr_ri   (div_waddr_r),
      .hold_o         (hold_o),
      .wb_we_o        (wb_we_o),
      .wb_waddr_o     (wb_waddr_o),
      .wb_wdata_o     (wb_wdata_o)
   );

   // RISC-V M-extension divide/remainder semantics.
   function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic               ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
      case (f3)
         3'b100:  return ovf ? a : 32'(sa / sb);
         3'b101:  return a / b;
         3'b110:  return ovf ? 32'd0 : 32'(sa % sb);
         default: return a % b;
      endcase
   endfunction

   // Divider stand-in: ready pulses a fixed number of cycles after start rises.
   always @(posedge clk) begin
      if (!div_start_o) begin
         cnt   <= 0;
         rdy_q <= 1'b0;
      end else if (rdy_q) begin
         rdy_q <= 1'b0;
      end else if (cnt >= lat_cfg) begin
         rdy_q <= 1'b1;
         res_q <= ref_div(div_op_o, div_dividend_o, div_divisor_o);
         wa_q  <= div_waddr_o;
      end else begin
         cnt <= cnt + 1;
      end
   end

   assign div_ready   = rdy_q | spur;
   assign div_waddr_r = spur ? (div_waddr_o ^ 5'd1) : wa_q;
   assign div_res     = spur ? 32'hDEAD_BEEF : res_q;
   assign div_busy    = (div_start_o & ~rdy_q) | busy_force;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // fl_mode: 0 none, 1 flush 6 cycles after issue, 2 flush with ready, 3 flush in DONE.
   task automatic run_div(input logic [2:0] op_v, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd_v, input int lat, input int spur_at,
                          input int busy_cyc, input int fl_mode);
      logic [31:0] exp_res;
      bit          fast;
      bit          done;
      bit          start_seen;
      int          n;
      int          exp_n;
      exp_res = ref_div(op_v, a, b);
`ifdef DIV_FASTPATH_EN
      fast = (b == 32'd0) || (!op_v[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`else
      fast = 1'b0;
`endif
      lat_cfg    = lat;
      busy_force = (busy_cyc > 0);
      ex_valid = 1'b1; is_div = 1'b1; op = op_v; rs1 = a; rs2 = b; rd = rd_v; flush = 1'b0;
      #1;
      chk("hold_issue", 32'(hold_o), 32'd1);
      for (int i = 0; i < busy_cyc; i++) begin
         @(posedge clk); #1;
         chk("busy_nostart", 32'(div_start_o), 32'd0);
         chk("busy_hold", 32'(hold_o), 32'd1);
      end
      busy_force = 1'b0;
      #1;
      n = 0; done = 1'b0; start_seen = 1'b0;
      while (!done && n < 200) begin
         @(posedge clk); #1;
         spur = 1'b0; flush = 1'b0;
         #1;
         n++;
         if (n == 1) chk("start_T1", 32'(div_start_o), fast ? 32'd0 : 32'd1);
         if (div_start_o) begin
            start_seen = 1'b1;
            chk("dividend", div_dividend_o, a);
            chk("divisor", div_divisor_o, b);
            chk("op", 32'(div_op_o), 32'(op_v));
            chk("waddr", 32'(div_waddr_o), 32'(rd_v));
         end
         if (!hold_o) begin
            done = 1'b1;
         end else begin
            chk("we_early", 32'(wb_we_o), 32'd0);
            if (spur_at != 0 && n == spur_at) spur = 1'b1;
            if (fl_mode == 1 && n == 6) begin flush = 1'b1; ex_valid = 1'b0; end
            if (fl_mode == 2 && rdy_q) begin flush = 1'b1; ex_valid = 1'b0; end
         end
      end
      chk("timeout", 32'(done), 32'd1);
      if (fl_mode == 1)      exp_n = 7;
      else if (fast)         exp_n = 1;
      else                   exp_n = lat + 3;
      chk("latency", 32'(n), 32'(exp_n));
      chk("start_used", 32'(start_seen), fast ? 32'd0 : 32'd1);
      if (fl_mode == 1 || fl_mode == 2) begin
         chk("flush_we", 32'(wb_we_o), 32'd0);
         chk("flush_start", 32'(div_start_o), 32'd0);
      end else begin
         if (fl_mode == 3) begin flush = 1'b1; #1; end
         chk("wb_we", 32'(wb_we_o), (rd_v != 5'd0) ? 32'd1 : 32'd0);
         if (rd_v != 5'd0) begin
            chk("wb_waddr", 32'(wb_waddr_o), 32'(rd_v));
            chk("wb_wdata", wb_wdata_o, exp_res);
         end
      end
      ex_valid = 1'b0; is_div = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
      chk("we_one_cycle", 32'(wb_we_o), 32'd0);
      chk("hold_after", 32'(hold_o), 32'd0);
      chk("start_after", 32'(div_start_o), 32'd0);
   endtask

   initial begin
      logic [2:0]  r_op;
      logic [31:0] r_a;
      logic [31:0] r_b;
      int          sel;

      #12;
      chk("rst_start", 32'(div_start_o), 32'd0);
      chk("rst_dividend", div_dividend_o, 32'd0);
      chk("rst_divisor", div_divisor_o, 32'd0);
      chk("rst_op", 32'(div_op_o), 32'd0);
      chk("rst_waddr", 32'(div_waddr_o), 32'd0);
      chk("rst_we", 32'(wb_we_o), 32'd0);
      chk("rst_wbaddr", 32'(wb_waddr_o), 32'd0);
      chk("rst_wdata", wb_wdata_o, 32'd0);
      chk("rst_hold", 32'(hold_o), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      run_div(3'b100, 32'h0000_000A, 32'h0000_0003, 5'd18, 4, 0, 0, 0);
      run_div(3'b100, 32'hFFFF_FFF6, 32'h0000_0003, 5'd7, 2, 0, 0, 0);
      run_div(3'b110, 32'hFFFF_FFF6, 32'h0000_0003, 5'd8, 0, 0, 0, 0);
      run_div(3'b110, 32'h0000_000A, 32'hFFFF_FFFD, 5'd9, 3, 0, 0, 0);
      run_div(3'b101, 32'hFFFF_FFF6, 32'h0000_0003, 5'd10, 1, 0, 0, 0);
      run_div(3'b111, 32'hFFFF_FFF6, 32'h0000_0003, 5'd11, 5, 0, 0, 0);
      run_div(3'b100, 32'h0000_0064, 32'h0000_0007, 5'd0, 2, 0, 0, 0);
      run_div(3'b100, 32'h0000_0064, 32'h0000_0007, 5'd12, 6, 3, 0, 0);
      run_div(3'b111, 32'h0000_004D, 32'h0000_0005, 5'd3, 1, 0, 3, 0);
      run_div(3'b100, 32'h1234_5678, 32'h0000_0010, 5'd4, 10, 0, 0, 1);
      run_div(3'b100, 32'h0000_0064, 32'h0000_000A, 5'd5, 2, 0, 0, 0);
      run_div(3'b101, 32'h0000_0064, 32'h0000_000A, 5'd6, 3, 0, 0, 2);
      run_div(3'b110, 32'h0000_0064, 32'h0000_0009, 5'd13, 2, 0, 0, 3);

      run_div(3'b100, 32'h0000_0007, 32'h0000_0000, 5'd14, 2, 0, 0, 0);
      run_div(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 2, 0, 0, 0);
      run_div(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 1, 0, 0, 0);
      run_div(3'b111, 32'hCAFE_0001, 32'h0000_0000, 5'd17, 1, 0, 0, 0);
      run_div(3'b101, 32'hCAFE_0001, 32'h0000_0000, 5'd19, 0, 0, 0, 0);

      // Non-divide and flushed divide must not stall or launch.
      ex_valid = 1'b1; is_div = 1'b0; op = 3'b100;
      #1;
      chk("nondiv_hold", 32'(hold_o), 32'd0);
      @(posedge clk); #1;
      chk("nondiv_start", 32'(div_start_o), 32'd0);
      is_div = 1'b1; flush = 1'b1;
      #1;
      chk("flushed_hold", 32'(hold_o), 32'd0);
      @(posedge clk); #1;
      chk("flushed_start", 32'(div_start_o), 32'd0);
      ex_valid = 1'b0; is_div = 1'b0; flush = 1'b0;
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a divide.
      lat_cfg = 20;
      ex_valid = 1'b1; is_div = 1'b1; op = 3'b101; rs1 = 32'hFFFF_0000; rs2 = 32'd3; rd = 5'd21;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_start", 32'(div_start_o), 32'd1);
      ex_valid = 1'b0; is_div = 1'b0;
      rst = 1'b0;
      #1;
      chk("arst_start", 32'(div_start_o), 32'd0);
      chk("arst_dividend", div_dividend_o, 32'd0);
      chk("arst_divisor", div_divisor_o, 32'd0);
      chk("arst_op", 32'(div_op_o), 32'd0);
      chk("arst_waddr", 32'(div_waddr_o), 32'd0);
      chk("arst_we", 32'(wb_we_o), 32'd0);
      chk("arst_wdata", wb_wdata_o, 32'd0);
      chk("arst_hold", 32'(hold_o), 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_div(3'b100, 32'h0000_000A, 32'h0000_0003, 5'd22, 3, 0, 0, 0);

      for (int k = 0; k < 25; k++) begin
         r_op = 3'(4 + $urandom_range(0, 3));
         r_a  = $urandom;
         sel  = $urandom_range(0, 7);
         if (sel == 0)      r_b = 32'd0;
         else if (sel == 1) r_b = 32'($urandom_range(1, 15));
         else if (sel == 2) begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
         else               r_b = $urandom;
         run_div(r_op, r_a, r_b, 5'($urandom_range(0, 31)), $urandom_range(0, 5), 0, 0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
